// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the
// five-stage MIPS core. It carries an opaque payload plus a valid bit across
// one stage boundary. It supports stall/hold, bubble insertion and flush, and
// it keeps saturating stall and bubble performance counters.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall           shared stall vector (bit i = stage i stalls)
//   flush           kill the entry at this boundary
//   valid_in        upstream entry is a real instruction
//   payload_in      upstream stage outputs
//   cnt_clr         synchronous clear of both counters
//   valid_out       registered valid
//   payload_out     registered payload
//   bubble_out      current entry came from bubble insertion
//   stall_cnt       cycles with the upstream stage stalled
//   bubble_cnt      bubbles inserted
module pipe_stage_reg #(
  parameter int                         PAYLOAD_WIDTH = 81,
  parameter int                         CTRL_WIDTH    = 6,
  parameter int                         STAGE         = 2,
  parameter logic [PAYLOAD_WIDTH-1:0]   BUBBLE_VALUE  = '0,
  parameter bit                         ZERO_INVALID  = 1'b1,
  parameter int                         CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CTRL_WIDTH-1:0]    stall,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [PAYLOAD_WIDTH-1:0] payload_in,
  input  logic                     cnt_clr,
  output logic                     valid_out,
  output logic [PAYLOAD_WIDTH-1:0] payload_out,
  output logic                     bubble_out,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     bubble_cnt
);

  logic up, dn;
  assign up = stall[STAGE];

  // The last boundary has no downstream stall bit, so it can never hold:
  // an upstream stall there always turns into a bubble.
  generate
    if (STAGE < CTRL_WIDTH-1) begin : g_dn
      assign dn = stall[STAGE+1];
    end else begin : g_no_dn
      assign dn = 1'b0;
    end
  endgenerate

  logic                     valid_q, valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic                     bubble_q, bubble_d;
  logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic                     bubble_taken;

  always_comb begin
    valid_d      = valid_q;
    payload_d    = payload_q;
    bubble_d     = bubble_q;
    bubble_taken = 1'b0;
    if (flush) begin
      // A flush wins over both stall and hold, and it is not counted as a bubble.
      valid_d   = 1'b0;
      payload_d = BUBBLE_VALUE;
      bubble_d  = 1'b0;
    end else if (up && !dn) begin
      valid_d      = 1'b0;
      payload_d    = BUBBLE_VALUE;
      bubble_d     = 1'b1;
      bubble_taken = 1'b1;
    end else if (up) begin
      // hold: keep the current entry
    end else begin
      valid_d   = valid_in;
      bubble_d  = 1'b0;
      payload_d = (ZERO_INVALID && !valid_in) ? BUBBLE_VALUE : payload_in;
    end
  end

  // Counters saturate at all-ones. A clear takes priority over an increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (up && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (bubble_taken && (bubble_cnt_q != '1))
        bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      payload_q    <= BUBBLE_VALUE;
      bubble_q     <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      payload_q    <= payload_d;
      bubble_q     <= bubble_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_out   = valid_q;
  assign payload_out = payload_q;
  assign bubble_out  = bubble_q;
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int PW = 81;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    stall;
  logic          flush, valid_in, cnt_clr;
  logic [PW-1:0] payload_in;

  // u0: default (ID/EX), u1: 4-bit counters, u2: last stage
  logic          v0, v1, v2, b0, b1, b2;
  logic [PW-1:0] p0, p1, p2;
  logic [15:0]   sc0, bc0, sc2, bc2;
  logic [3:0]    sc1, bc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .payload_in(payload_in), .cnt_clr(cnt_clr), .valid_out(v0), .payload_out(p0),
    .bubble_out(b0), .stall_cnt(sc0), .bubble_cnt(bc0));

  pipe_stage_reg #(.CNT_WIDTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .payload_in(payload_in), .cnt_clr(cnt_clr), .valid_out(v1), .payload_out(p1),
    .bubble_out(b1), .stall_cnt(sc1), .bubble_cnt(bc1));

  pipe_stage_reg #(.STAGE(5)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .payload_in(payload_in), .cnt_clr(cnt_clr), .valid_out(v2), .payload_out(p2),
    .bubble_out(b2), .stall_cnt(sc2), .bubble_cnt(bc2));

  // Reference model: what each boundary should hold, derived from the
  // reset/flush/bubble/hold/advance rules with plain integer counters.
  typedef struct {
    bit            v;
    logic [PW-1:0] p;
    bit            b;
    int            sc;
    int            bc;
  } ms_t;

  ms_t m[3];
  int  stg[3]  = '{2, 2, 5};
  int  cmax[3] = '{65535, 15, 65535};

  function automatic ms_t step(ms_t s, int stage, int mx);
    ms_t n = s;
    bit up, dn, bub;
    up  = stall[stage];
    dn  = (stage < 5) ? stall[stage+1] : 1'b0;
    bub = 0;
    if (!rst_n) begin
      n.v = 0; n.p = '0; n.b = 0; n.sc = 0; n.bc = 0;
      return n;
    end
    if (flush) begin
      n.v = 0; n.p = '0; n.b = 0;
    end else if (up && !dn) begin
      n.v = 0; n.p = '0; n.b = 1; bub = 1;
    end else if (!up) begin
      n.v = valid_in; n.b = 0;
      n.p = valid_in ? payload_in : '0;
    end
    if (cnt_clr) begin
      n.sc = 0; n.bc = 0;
    end else begin
      if (up)  n.sc = (s.sc < mx) ? s.sc + 1 : mx;
      if (bub) n.bc = (s.bc < mx) ? s.bc + 1 : mx;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u0.valid", 128'(v0), 128'(m[0].v));
    chk("u0.payload", 128'(p0), 128'(m[0].p));
    chk("u0.bubble", 128'(b0), 128'(m[0].b));
    chk("u0.stall_cnt", 128'(sc0), 128'(m[0].sc));
    chk("u0.bubble_cnt", 128'(bc0), 128'(m[0].bc));
    chk("u1.valid", 128'(v1), 128'(m[1].v));
    chk("u1.payload", 128'(p1), 128'(m[1].p));
    chk("u1.bubble", 128'(b1), 128'(m[1].b));
    chk("u1.stall_cnt", 128'(sc1), 128'(m[1].sc));
    chk("u1.bubble_cnt", 128'(bc1), 128'(m[1].bc));
    chk("u2.valid", 128'(v2), 128'(m[2].v));
    chk("u2.payload", 128'(p2), 128'(m[2].p));
    chk("u2.bubble", 128'(b2), 128'(m[2].b));
    chk("u2.stall_cnt", 128'(sc2), 128'(m[2].sc));
    chk("u2.bubble_cnt", 128'(bc2), 128'(m[2].bc));
  endtask

  // One clock: the model advances on the inputs present at the edge,
  // and the outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = step(m[i], stg[i], cmax[i]);
    #1;
    check_all();
  endtask

  function automatic logic [PW-1:0] rnd_payload();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  initial begin
    logic [PW-1:0] frozen;
    for (int i = 0; i < 3; i++) begin
      m[i].v = 0; m[i].p = '0; m[i].b = 0; m[i].sc = 0; m[i].bc = 0;
    end
    rst_n = 0; stall = '0; flush = 0; valid_in = 1; cnt_clr = 0;
    payload_in = '1;

    // reset for two cycles with all-ones payload
    tick(); tick();
    chk("reset.valid", 128'(v0), 128'(0));
    chk("reset.payload", 128'(p0), 128'(0));
    chk("reset.stall_cnt", 128'(sc0), 128'(0));

    // advance
    rst_n = 1;
    payload_in = 81'h1_2345_6789_ABCD_EF01;
    tick();
    chk("adv.payload", 128'(p0), 128'h1_2345_6789_ABCD_EF01);
    chk("adv.valid", 128'(v0), 128'(1));
    valid_in = 0;
    tick();
    chk("adv.zero_invalid", 128'(p0), 128'(0));

    // bubble
    valid_in = 1; payload_in = 81'h0_0000_0000_DEAD_BEEF;
    tick();
    payload_in = 81'h0_0000_0000_0000_0055;
    tick();
    stall = 6'b000111;
    tick();
    chk("bub.bubble_out", 128'(b0), 128'(1));
    chk("bub.bubble_cnt", 128'(bc0), 128'(1));
    chk("bub.payload", 128'(p0), 128'(0));

    // hold for three cycles with changing payload
    stall = 6'b001111;
    frozen = p0;
    for (int k = 0; k < 3; k++) begin
      payload_in = rnd_payload();
      tick();
      chk("hold.payload", 128'(p0), 128'(frozen));
    end
    chk("hold.stall_cnt", 128'(sc0), 128'(4));

    // release: the payload present in the release cycle advances
    stall = 6'b000000; payload_in = 81'h1_0000_0000_0000_0ABC;
    tick();
    chk("release.payload", 128'(p0), 128'h1_0000_0000_0000_0ABC);

    // flush beats bubble
    stall = 6'b000111; flush = 1;
    tick();
    chk("flush.bubble_out", 128'(b0), 128'(0));
    chk("flush.bubble_cnt", 128'(bc0), 128'(1));
    chk("flush.stall_cnt", 128'(sc0), 128'(5));
    stall = 6'b000000; flush = 0; payload_in = 81'h0_0000_0000_0000_1234;
    tick();
    chk("post_flush.payload", 128'(p0), 128'h1234);

    // saturation (u1) and last stage (u2) bubbling every cycle
    stall = 6'b100100;
    for (int k = 0; k < 20; k++) tick();
    chk("sat.stall_cnt", 128'(sc1), 128'(15));
    chk("last.bubble_cnt", 128'(bc2), 128'(20));
    chk("last.bubble_out", 128'(b2), 128'(1));
    cnt_clr = 1;
    tick();
    chk("clr.stall_cnt", 128'(sc1), 128'(0));
    chk("clr.bubble_cnt", 128'(bc2), 128'(0));
    cnt_clr = 0;

    // randomized phase against the model
    for (int k = 0; k < 400; k++) begin
      stall      = 6'($urandom);
      if ($urandom_range(0, 2) == 0) stall = '0;
      if ($urandom_range(0, 3) == 0) stall = 6'b001100;
      flush      = ($urandom_range(0, 7) == 0);
      cnt_clr    = ($urandom_range(0, 15) == 0);
      rst_n      = ($urandom_range(0, 39) != 0);
      valid_in   = 1'($urandom);
      payload_in = rnd_payload();
      tick();
    end

    // long stall run to saturate the 4-bit counters again
    rst_n = 1; flush = 0; cnt_clr = 0; stall = 6'b000100;
    for (int k = 0; k < 20; k++) tick();
    chk("sat2.bubble_cnt", 128'(bc1), 128'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
